// File: rtl/pipe_scheduler_if.sv
// rtl/pipe_scheduler_if.sv - gap-table fetch handshake between scheduler and gap table
interface pipe_scheduler_if;
  logic        GapReq;
  logic        GapPipe;
  logic [5:0]  GapIndex;
  logic        GapAck;
  logic [15:0] GapData;

  modport master (
    output GapReq,
    output GapPipe,
    output GapIndex,
    input  GapAck,
    input  GapData
  );

  modport slave (
    input  GapReq,
    input  GapPipe,
    input  GapIndex,
    output GapAck,
    output GapData
  );
endinterface

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - game-flow FSM, pipe scrolling, gap fetch and scoring
module pipe_scheduler #(
  parameter int SCREEN_W     = 640,
  parameter int PIPE_SPACING = 320,
  parameter int SPEED        = 2,
  parameter int BIRD_X       = 160,
  parameter int NUM_PATTERNS = 5,
  parameter int SEQ_LEN      = 50
) (
  input  logic                Clks,
  input  logic                Reset,
  input  logic                Button,
  input  logic                FrameTick,
  input  logic                Collision,
  pipe_scheduler_if.master    gap,
  output logic [2:0]          PatternSel,
  output logic [15:0]         PipesPosition1,
  output logic [15:0]         PipesPosition2,
  output logic [15:0]         Gap1,
  output logic [15:0]         Gap2,
  output logic [15:0]         Score,
  output logic [1:0]          State
);

  localparam logic [15:0] POS1_INIT = 16'(SCREEN_W);
  localparam logic [15:0] POS2_INIT = 16'(SCREEN_W + PIPE_SPACING);
  localparam logic [15:0] SPEED_W   = 16'(SPEED);
  localparam logic [15:0] BIRD_W    = 16'(BIRD_X);
  localparam logic [15:0] SCORE_MAX = 16'd9999;
  localparam logic [2:0]  PAT_LAST  = 3'(NUM_PATTERNS);
  localparam logic [5:0]  IDX_LAST  = 6'(SEQ_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  pat_cnt_q, pat_cnt_d;
  logic [2:0]  pat_sel_q, pat_sel_d;
  logic        armed_q, armed_d;
  logic [15:0] pos1_q, pos1_d, pos2_q, pos2_d;
  logic [5:0]  idx1_q, idx1_d, idx2_q, idx2_d;
  logic        pend1_q, pend1_d, pend2_q, pend2_d;
  logic        req_q, req_d;
  logic        req_pipe_q, req_pipe_d;
  logic [5:0]  req_idx_q, req_idx_d;
  logic [15:0] gap1_q, gap1_d, gap2_q, gap2_d;
  logic [15:0] score_q, score_d;

  logic        xfer, ack1, ack2, set1, set2, clr_pend;
  logic [1:0]  inc;
  logic [16:0] score_sum;

  // Next-state logic: game FSM, pipe scroll, pending-fetch service and handshake
  always_comb begin
    state_d    = state_q;
    pat_cnt_d  = pat_cnt_q;
    pat_sel_d  = pat_sel_q;
    armed_d    = armed_q;
    pos1_d     = pos1_q;
    pos2_d     = pos2_q;
    idx1_d     = idx1_q;
    idx2_d     = idx2_q;
    req_d      = req_q;
    req_pipe_d = req_pipe_q;
    req_idx_d  = req_idx_q;
    gap1_d     = gap1_q;
    gap2_d     = gap2_q;
    score_d    = score_q;
    set1       = 1'b0;
    set2       = 1'b0;
    clr_pend   = 1'b0;
    inc        = 2'd0;
    score_sum  = 17'd0;

    // An ack only counts while our request is up; a stray ack is ignored.
    xfer = req_q & gap.GapAck;
    ack1 = xfer & ~req_pipe_q;
    ack2 = xfer & req_pipe_q;
    if (xfer) begin
      req_d = 1'b0;
      if (req_pipe_q) gap2_d = gap.GapData;
      else            gap1_d = gap.GapData;
    end

    case (state_q)
      S_IDLE: begin
        pat_cnt_d = (pat_cnt_q == PAT_LAST) ? 3'd1 : pat_cnt_q + 3'd1;
        // A button still held from the previous game must be released first.
        if (Button) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d   = 1'b0;
          pat_sel_d = pat_cnt_q;
          score_d   = 16'd0;
          set1      = 1'b1;
          set2      = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        // Pipe 1 is always fetched first, so pipe 2's ack ends loading.
        if (ack2 && !pend1_q) state_d = S_RUN;
      end
      S_RUN: begin
        // Collision wins over the frame tick, freezing this frame's positions.
        if (Collision) begin
          state_d = S_DEAD;
        end else if (FrameTick) begin
          if (pos1_q <= SPEED_W) begin
            pos1_d = POS1_INIT;
            idx1_d = (idx1_q == IDX_LAST) ? 6'd1 : idx1_q + 6'd1;
            set1   = 1'b1;
          end else begin
            pos1_d = pos1_q - SPEED_W;
            if (pos1_q > BIRD_W && pos1_d <= BIRD_W) inc = inc + 2'd1;
          end
          if (pos2_q <= SPEED_W) begin
            pos2_d = POS1_INIT;
            idx2_d = (idx2_q == IDX_LAST) ? 6'd1 : idx2_q + 6'd1;
            set2   = 1'b1;
          end else begin
            pos2_d = pos2_q - SPEED_W;
            if (pos2_q > BIRD_W && pos2_d <= BIRD_W) inc = inc + 2'd1;
          end
        end
      end
      S_DEAD: begin
        // Wait for any in-flight fetch so a new game never inherits a stale ack.
        if (Button) begin
          armed_d = 1'b1;
        end else if (armed_q && !req_q) begin
          armed_d  = 1'b0;
          state_d  = S_IDLE;
          pos1_d   = POS1_INIT;
          pos2_d   = POS2_INIT;
          idx1_d   = 6'd1;
          idx2_d   = 6'd1;
          clr_pend = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    score_sum = {1'b0, score_q} + {15'd0, inc};
    if (inc != 2'd0) begin
      score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[15:0];
    end

    // A wrap on the same cycle as an older ack keeps the flag set.
    pend1_d = clr_pend ? 1'b0 : ((pend1_q & ~ack1) | set1);
    pend2_d = clr_pend ? 1'b0 : ((pend2_q & ~ack2) | set2);

    // Index is captured at issue so it stays fixed while the request waits.
    if (!req_q && (state_q == S_LOAD || state_q == S_RUN)) begin
      if (pend1_q) begin
        req_d      = 1'b1;
        req_pipe_d = 1'b0;
        req_idx_d  = idx1_q;
      end else if (pend2_q) begin
        req_d      = 1'b1;
        req_pipe_d = 1'b1;
        req_idx_d  = idx2_q;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clks) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      pat_cnt_q  <= 3'd1;
      pat_sel_q  <= 3'd1;
      armed_q    <= 1'b0;
      pos1_q     <= POS1_INIT;
      pos2_q     <= POS2_INIT;
      idx1_q     <= 6'd1;
      idx2_q     <= 6'd1;
      pend1_q    <= 1'b0;
      pend2_q    <= 1'b0;
      req_q      <= 1'b0;
      req_pipe_q <= 1'b0;
      req_idx_q  <= 6'd1;
      gap1_q     <= 16'd0;
      gap2_q     <= 16'd0;
      score_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      pat_cnt_q  <= pat_cnt_d;
      pat_sel_q  <= pat_sel_d;
      armed_q    <= armed_d;
      pos1_q     <= pos1_d;
      pos2_q     <= pos2_d;
      idx1_q     <= idx1_d;
      idx2_q     <= idx2_d;
      pend1_q    <= pend1_d;
      pend2_q    <= pend2_d;
      req_q      <= req_d;
      req_pipe_q <= req_pipe_d;
      req_idx_q  <= req_idx_d;
      gap1_q     <= gap1_d;
      gap2_q     <= gap2_d;
      score_q    <= score_d;
    end
  end

  assign gap.GapReq     = req_q;
  assign gap.GapPipe    = req_pipe_q;
  assign gap.GapIndex   = req_idx_q;
  assign PatternSel     = pat_sel_q;
  assign PipesPosition1 = pos1_q;
  assign PipesPosition2 = pos2_q;
  assign Gap1           = gap1_q;
  assign Gap2           = gap2_q;
  assign Score          = score_q;
  assign State          = state_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - self-checking bench for pipe_scheduler
module tb_pipe_scheduler;

  localparam int SCREEN_W = 640;
  localparam int PIPE_SPACING = 320;
  localparam int SPEED = 2;
  localparam int BIRD_X = 160;
  localparam int NUM_PATTERNS = 5;
  localparam int SEQ_LEN = 50;

  logic        Clks;
  logic        Reset;
  logic        Button;
  logic        FrameTick;
  logic        Collision;
  logic [2:0]  PatternSel;
  logic [15:0] PipesPosition1, PipesPosition2, Gap1, Gap2, Score;
  logic [1:0]  State;

  pipe_scheduler_if gap_bus ();

  pipe_scheduler dut (
    .Clks           (Clks),
    .Reset          (Reset),
    .Button         (Button),
    .FrameTick      (FrameTick),
    .Collision      (Collision),
    .gap            (gap_bus.master),
    .PatternSel     (PatternSel),
    .PipesPosition1 (PipesPosition1),
    .PipesPosition2 (PipesPosition2),
    .Gap1           (Gap1),
    .Gap2           (Gap2),
    .Score          (Score),
    .State          (State)
  );

  int checks = 0;
  int errors = 0;

  // gap-table responder control and transfer log
  int          resp_budget = 0;
  int          resp_delay  = 0;
  logic [15:0] data_q[$];
  logic        log_pipe[$];
  logic [5:0]  log_idx[$];
  logic [15:0] log_data[$];

  // reference model state
  int   m_p1, m_p2, m_i1, m_i2, m_sc;
  logic exp_pipe[$];
  int   exp_idx[$];

  initial Clks = 1'b0;
  always #5 Clks = ~Clks;

  initial begin : responder
    int          wait_cnt;
    logic        ack_pipe;
    logic [5:0]  ack_idx;
    gap_bus.GapAck  = 1'b0;
    gap_bus.GapData = 16'd0;
    wait_cnt = 0;
    ack_pipe = 1'b0;
    ack_idx  = 6'd0;
    forever begin
      @(posedge Clks);
      #1;
      if (gap_bus.GapAck) begin
        gap_bus.GapAck = 1'b0;
        log_pipe.push_back(ack_pipe);
        log_idx.push_back(ack_idx);
        log_data.push_back(gap_bus.GapData);
      end else if (gap_bus.GapReq && resp_budget != 0) begin
        if (wait_cnt >= resp_delay) begin
          if (data_q.size() > 0) gap_bus.GapData = data_q.pop_front();
          else gap_bus.GapData = 16'($urandom_range(40, 400));
          gap_bus.GapAck = 1'b1;
          ack_pipe = gap_bus.GapPipe;
          ack_idx  = gap_bus.GapIndex;
          wait_cnt = 0;
          if (resp_budget > 0) resp_budget = resp_budget - 1;
        end else begin
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge Clks);
    #2;
  endtask

  task automatic frame_tick();
    FrameTick = 1'b1;
    cyc();
    FrameTick = 1'b0;
  endtask

  task automatic clear_log();
    log_pipe.delete();
    log_idx.delete();
    log_data.delete();
  endtask

  // one frame of the game rules, applied to the model
  task automatic model_tick();
    int old;
    old = m_p1;
    if (m_p1 <= SPEED) begin
      m_p1 = SCREEN_W;
      m_i1 = (m_i1 % SEQ_LEN) + 1;
      exp_pipe.push_back(1'b0);
      exp_idx.push_back(m_i1);
    end else begin
      m_p1 = m_p1 - SPEED;
      if (old > BIRD_X && m_p1 <= BIRD_X) m_sc = m_sc + 1;
    end
    old = m_p2;
    if (m_p2 <= SPEED) begin
      m_p2 = SCREEN_W;
      m_i2 = (m_i2 % SEQ_LEN) + 1;
      exp_pipe.push_back(1'b1);
      exp_idx.push_back(m_i2);
    end else begin
      m_p2 = m_p2 - SPEED;
      if (old > BIRD_X && m_p2 <= BIRD_X) m_sc = m_sc + 1;
    end
    if (m_sc > 9999) m_sc = 9999;
  endtask

  task automatic test_reset();
    Button = 1'b0; FrameTick = 1'b0; Collision = 1'b0; Reset = 1'b0;
    repeat (3) cyc();
    checks++; if (State !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", State); end
    checks++; if (PipesPosition1 !== 16'(SCREEN_W)) begin errors++; $display("FAIL reset_pos1 got %0d exp %0d", PipesPosition1, SCREEN_W); end
    checks++; if (PipesPosition2 !== 16'(SCREEN_W + PIPE_SPACING)) begin errors++; $display("FAIL reset_pos2 got %0d exp %0d", PipesPosition2, SCREEN_W + PIPE_SPACING); end
    checks++; if ({Gap1, Gap2, Score} !== 48'd0) begin errors++; $display("FAIL reset_gap_score got %0d/%0d/%0d exp 0/0/0", Gap1, Gap2, Score); end
    checks++; if ({gap_bus.GapReq, gap_bus.GapIndex, PatternSel} !== {1'b0, 6'd1, 3'd1}) begin
      errors++; $display("FAIL reset_req_idx_pat got %0d/%0d/%0d exp 0/1/1", gap_bus.GapReq, gap_bus.GapIndex, PatternSel);
    end
    Reset = 1'b1;
    repeat (6) cyc();
    checks++; if (State !== 2'd0) begin errors++; $display("FAIL held_button_no_start got %0d exp 0", State); end
    Reset = 1'b0; Button = 1'b1;
    repeat (2) cyc();
    Reset = 1'b1;
  endtask

  task automatic test_start();
    int n;
    int exp_pat;
    n = $urandom_range(1, 9);
    repeat (n) cyc();
    exp_pat = (n % NUM_PATTERNS) + 1;
    Button = 1'b0;
    cyc();
    Button = 1'b1;
    checks++; if (PatternSel !== 3'(exp_pat)) begin errors++; $display("FAIL pattern_sel got %0d exp %0d", PatternSel, exp_pat); end
    checks++; if (State !== 2'd1) begin errors++; $display("FAIL start_state got %0d exp 1", State); end
    cyc();
    checks++; if ({gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex} !== {1'b1, 1'b0, 6'd1}) begin
      errors++; $display("FAIL load_req1 got %0d/%0d/%0d exp 1/0/1", gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex);
    end
    FrameTick = 1'b1; Collision = 1'b1;
    repeat (2) cyc();
    FrameTick = 1'b0; Collision = 1'b0;
    checks++; if ({State, PipesPosition1} !== {2'd1, 16'(SCREEN_W)}) begin
      errors++; $display("FAIL load_ignores_tick got %0d/%0d exp 1/%0d", State, PipesPosition1, SCREEN_W);
    end
    clear_log();
    data_q.push_back(16'd80);
    data_q.push_back(16'd140);
    resp_delay = 1;
    resp_budget = 2;
    for (int k = 0; k < 60 && State !== 2'd2; k++) cyc();
    checks++; if (State !== 2'd2) begin errors++; $display("FAIL load_to_run got %0d exp 2", State); end
    checks++;
    if (log_pipe.size() != 2) begin
      errors++; $display("FAIL load_fetch_count got %0d exp 2", log_pipe.size());
    end else if ({log_pipe[0], log_idx[0], log_pipe[1], log_idx[1]} !== {1'b0, 6'd1, 1'b1, 6'd1}) begin
      errors++; $display("FAIL load_fetch_order got %0d:%0d,%0d:%0d exp 0:1,1:1", log_pipe[0], log_idx[0], log_pipe[1], log_idx[1]);
    end
    checks++; if ({Gap1, Gap2} !== {16'd80, 16'd140}) begin errors++; $display("FAIL load_gaps got %0d/%0d exp 80/140", Gap1, Gap2); end
  endtask

  task automatic test_scroll();
    repeat (240) frame_tick();
    checks++; if ({PipesPosition1, PipesPosition2, Score} !== {16'd160, 16'd480, 16'd1}) begin
      errors++; $display("FAIL scroll_240 got %0d/%0d/%0d exp 160/480/1", PipesPosition1, PipesPosition2, Score);
    end
    resp_budget = 0;
    repeat (80) frame_tick();
    checks++; if ({PipesPosition1, PipesPosition2, Score} !== {16'd640, 16'd320, 16'd1}) begin
      errors++; $display("FAIL wrap_320 got %0d/%0d/%0d exp 640/320/1", PipesPosition1, PipesPosition2, Score);
    end
    cyc();
    checks++; if ({gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex} !== {1'b1, 1'b0, 6'd2}) begin
      errors++; $display("FAIL wrap_req got %0d/%0d/%0d exp 1/0/2", gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex);
    end
  endtask

  task automatic test_ack_stall();
    for (int k = 0; k < 20; k++) begin
      cyc();
      checks++;
      if ({gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex, Gap1} !== {1'b1, 1'b0, 6'd2, 16'd80}) begin
        errors++; $display("FAIL stall_stable cyc %0d got %0d/%0d/%0d/%0d exp 1/0/2/80", k, gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex, Gap1);
      end
    end
  endtask

  task automatic test_pipe2_order();
    for (int k = 0; k < 160; k++) begin
      frame_tick();
      checks++;
      if ({gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex} !== {1'b1, 1'b0, 6'd2}) begin
        errors++; $display("FAIL pipe2_waits tick %0d got %0d/%0d/%0d exp 1/0/2", k, gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex);
      end
    end
    checks++; if ({PipesPosition1, PipesPosition2, Score} !== {16'd320, 16'd640, 16'd2}) begin
      errors++; $display("FAIL tick_480 got %0d/%0d/%0d exp 320/640/2", PipesPosition1, PipesPosition2, Score);
    end
    clear_log();
    data_q.push_back(16'd110);
    resp_delay = 0;
    resp_budget = 1;
    for (int k = 0; k < 50 && log_pipe.size() < 1; k++) cyc();
    checks++; if ({gap_bus.GapReq, Gap1, Gap2} !== {1'b0, 16'd110, 16'd140}) begin
      errors++; $display("FAIL ack1_done got %0d/%0d/%0d exp 0/110/140", gap_bus.GapReq, Gap1, Gap2);
    end
    cyc();
    checks++; if ({gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex} !== {1'b1, 1'b1, 6'd2}) begin
      errors++; $display("FAIL pipe2_req got %0d/%0d/%0d exp 1/1/2", gap_bus.GapReq, gap_bus.GapPipe, gap_bus.GapIndex);
    end
    data_q.push_back(16'd200);
    resp_budget = 1;
    for (int k = 0; k < 50 && log_pipe.size() < 2; k++) cyc();
    checks++; if ({gap_bus.GapReq, Gap2} !== {1'b0, 16'd200}) begin
      errors++; $display("FAIL ack2_done got %0d/%0d exp 0/200", gap_bus.GapReq, Gap2);
    end
  endtask

  task automatic test_random_run();
    logic [15:0] last1;
    bit          seen1;
    m_p1 = 320; m_p2 = 640; m_i1 = 2; m_i2 = 2; m_sc = 2;
    exp_pipe.delete();
    exp_idx.delete();
    clear_log();
    resp_budget = -1;
    seen1 = 1'b0;
    last1 = 16'd0;
    for (int t = 0; t < 700; t++) begin
      if (t % 50 == 0) resp_delay = $urandom_range(0, 8);
      repeat ($urandom_range(0, 2)) cyc();
      frame_tick();
      model_tick();
      checks++;
      if ({PipesPosition1, PipesPosition2, Score} !== {16'(m_p1), 16'(m_p2), 16'(m_sc)}) begin
        errors++; $display("FAIL rand_tick %0d got %0d/%0d/%0d exp %0d/%0d/%0d", t, PipesPosition1, PipesPosition2, Score, m_p1, m_p2, m_sc);
      end
    end
    repeat (30) cyc();
    checks++;
    if (log_pipe.size() != exp_pipe.size()) begin
      errors++; $display("FAIL rand_fetch_count got %0d exp %0d", log_pipe.size(), exp_pipe.size());
    end else begin
      for (int k = 0; k < log_pipe.size(); k++) begin
        checks++;
        if ({log_pipe[k], log_idx[k]} !== {exp_pipe[k], 6'(exp_idx[k])}) begin
          errors++; $display("FAIL rand_fetch %0d got %0d:%0d exp %0d:%0d", k, log_pipe[k], log_idx[k], exp_pipe[k], exp_idx[k]);
        end
        if (log_pipe[k] == 1'b0) begin seen1 = 1'b1; last1 = log_data[k]; end
      end
    end
    if (seen1) begin
      checks++; if (Gap1 !== last1) begin errors++; $display("FAIL rand_gap1 got %0d exp %0d", Gap1, last1); end
    end
  endtask

  task automatic test_collision_dead();
    Button = 1'b0;
    Collision = 1'b1; FrameTick = 1'b1;
    cyc();
    Collision = 1'b0; FrameTick = 1'b0;
    checks++; if ({State, PipesPosition1, PipesPosition2} !== {2'd3, 16'(m_p1), 16'(m_p2)}) begin
      errors++; $display("FAIL collide got %0d/%0d/%0d exp 3/%0d/%0d", State, PipesPosition1, PipesPosition2, m_p1, m_p2);
    end
    repeat (10) frame_tick();
    checks++; if ({State, PipesPosition1, PipesPosition2, Score} !== {2'd3, 16'(m_p1), 16'(m_p2), 16'(m_sc)}) begin
      errors++; $display("FAIL dead_frozen got %0d/%0d/%0d/%0d exp 3/%0d/%0d/%0d", State, PipesPosition1, PipesPosition2, Score, m_p1, m_p2, m_sc);
    end
    Button = 1'b1;
    cyc();
    Button = 1'b0;
    cyc();
    Button = 1'b1;
    checks++; if ({State, PipesPosition1, PipesPosition2, Score} !== {2'd0, 16'(SCREEN_W), 16'(SCREEN_W + PIPE_SPACING), 16'(m_sc)}) begin
      errors++; $display("FAIL dead_to_idle got %0d/%0d/%0d/%0d exp 0/%0d/%0d/%0d", State, PipesPosition1, PipesPosition2, Score, SCREEN_W, SCREEN_W + PIPE_SPACING, m_sc);
    end
  endtask

  task automatic test_index_wrap();
    int n;
    clear_log();
    resp_delay = 0;
    resp_budget = -1;
    cyc();
    Button = 1'b0;
    cyc();
    Button = 1'b1;
    checks++; if ({State, Score} !== {2'd1, 16'd0}) begin errors++; $display("FAIL restart got %0d/%0d exp 1/0", State, Score); end
    for (int k = 0; k < 60 && State !== 2'd2; k++) cyc();
    repeat (50 * 320) frame_tick();
    repeat (10) cyc();
    n = 0;
    for (int k = 0; k < log_pipe.size(); k++) begin
      if (log_pipe[k] == 1'b0) begin
        checks++;
        if (log_idx[k] !== 6'((n % SEQ_LEN) + 1)) begin
          errors++; $display("FAIL idx_seq %0d got %0d exp %0d", n, log_idx[k], (n % SEQ_LEN) + 1);
        end
        n++;
      end
    end
    checks++; if (n != 51) begin errors++; $display("FAIL idx_seq_count got %0d exp 51", n); end
  endtask

  task automatic test_reset_mid_request();
    resp_budget = 0;
    for (int k = 0; k < 400 && gap_bus.GapReq !== 1'b1; k++) frame_tick();
    checks++; if (gap_bus.GapReq !== 1'b1) begin errors++; $display("FAIL mid_req_raise got %0d exp 1", gap_bus.GapReq); end
    Reset = 1'b0;
    cyc();
    checks++; if ({gap_bus.GapReq, State, PipesPosition1} !== {1'b0, 2'd0, 16'(SCREEN_W)}) begin
      errors++; $display("FAIL reset_mid_req got %0d/%0d/%0d exp 0/0/%0d", gap_bus.GapReq, State, PipesPosition1, SCREEN_W);
    end
    Reset = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_start();
    test_scroll();
    test_ack_stall();
    test_pipe2_order();
    test_random_run();
    test_collision_dead();
    test_index_wrap();
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
